// File: rtl/rv32i.sv
// Shared types and constants for the RV32I core.
// Holds the pipeline sequencing state encoding and the drain depth.
// Imported by the pipeline controller and its helpers.
package rv32i;

    typedef enum logic [2:0] {
        PS_RUN      = 3'd0,
        PS_MEM_WAIT = 3'd1,
        PS_DRAIN    = 3'd2,
        PS_HALTED   = 3'd3,
        PS_FAULT    = 3'd4
    } pipe_state_t;

    // Number of clean ID->EX advances needed to empty the front of the pipe.
    localparam int PIPE_DRAIN_DEPTH = 4;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
// Latency: count reflects inc one cycle later.
// Backpressure: none; inc is sampled every cycle.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next value: step unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + WIDTH'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline sequencer: stalls, flushes, DMEM freeze, debug halt, timeout fault.
// Latency: enables/flushes are combinational; halt_ack/mem_fault/counters are registered.
// Backpressure: a not-ready DMEM access freezes every stage except WB, which takes bubbles.
module pipeline_ctrl
    import rv32i::*;
#(
    parameter int TIMEOUT   = 64,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           id_rs1,
    input  logic [4:0]           id_rs2,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic [4:0]           ex_rd,
    input  logic                 ex_mem_read,
    input  logic                 ex_redirect,
    input  logic                 mem_req,
    input  logic                 dmem_ready,
    input  logic                 halt_req,
    input  logic                 resume_req,
    output logic                 pc_en,
    output logic                 if_id_en,
    output logic                 id_ex_en,
    output logic                 ex_mem_en,
    output logic                 mem_wb_en,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 mem_wb_flush,
    output logic                 pc_sel_redirect,
    output logic                 halt_ack,
    output logic                 mem_fault,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] redirect_count
);

    localparam int WAIT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    pipe_state_t       state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [2:0]        drain_cnt_q, drain_cnt_d;
    logic              from_drain_q, from_drain_d;

    logic freeze;
    logic load_use;
    logic active;
    logic drain_mode;
    logic drain_step;

    assign freeze   = mem_req & ~dmem_ready;
    assign load_use = ex_mem_read & (ex_rd != 5'd0) &
                      ((id_uses_rs1 & (id_rs1 == ex_rd)) | (id_uses_rs2 & (id_rs2 == ex_rd)));
    assign active   = (state_q == PS_RUN) | (state_q == PS_MEM_WAIT) | (state_q == PS_DRAIN);
    // A DMEM wait entered from DRAIN keeps draining behaviour so no new fetch slips in.
    assign drain_mode = (state_q == PS_DRAIN) | ((state_q == PS_MEM_WAIT) & from_drain_q);
    assign drain_step = id_ex_en & ~freeze & ~load_use;

    // Enable/flush decode by priority: freeze, redirect, load-use, free-run.
    always_comb begin
        pc_en           = 1'b0;
        if_id_en        = 1'b0;
        id_ex_en        = 1'b0;
        ex_mem_en       = 1'b0;
        mem_wb_en       = 1'b0;
        if_id_flush     = 1'b0;
        id_ex_flush     = 1'b0;
        mem_wb_flush    = 1'b0;
        pc_sel_redirect = 1'b0;
        if (active && !rst) begin
            if (freeze) begin
                mem_wb_en    = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (ex_redirect) begin
                pc_en           = 1'b1;
                if_id_en        = 1'b1;
                id_ex_en        = 1'b1;
                ex_mem_en       = 1'b1;
                mem_wb_en       = 1'b1;
                pc_sel_redirect = 1'b1;
                if_id_flush     = 1'b1;
                id_ex_flush     = 1'b1;
            end else if (load_use) begin
                id_ex_en    = 1'b1;
                ex_mem_en   = 1'b1;
                mem_wb_en   = 1'b1;
                id_ex_flush = 1'b1;
            end else begin
                pc_en     = 1'b1;
                if_id_en  = 1'b1;
                id_ex_en  = 1'b1;
                ex_mem_en = 1'b1;
                mem_wb_en = 1'b1;
            end
            if (drain_mode) begin
                pc_en = pc_en & pc_sel_redirect;
                if (if_id_en) begin
                    if_id_flush = 1'b1;
                end
            end
        end
    end

    // Next-state logic for the sequencing FSM and its wait/drain bookkeeping.
    always_comb begin
        state_d      = state_q;
        wait_cnt_d   = wait_cnt_q;
        drain_cnt_d  = drain_cnt_q;
        from_drain_d = from_drain_q;
        case (state_q)
            PS_RUN: begin
                if (freeze) begin
                    state_d      = PS_MEM_WAIT;
                    wait_cnt_d   = '0;
                    from_drain_d = 1'b0;
                end else if (halt_req && !ex_redirect) begin
                    state_d     = PS_DRAIN;
                    drain_cnt_d = '0;
                end
            end
            PS_MEM_WAIT: begin
                if (freeze) begin
                    if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
                        state_d = PS_FAULT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end else if (from_drain_q) begin
                    state_d = PS_DRAIN;
                    if (drain_step) begin
                        if (drain_cnt_q == 3'(PIPE_DRAIN_DEPTH - 1)) begin
                            state_d = PS_HALTED;
                        end
                        drain_cnt_d = drain_cnt_q + 3'd1;
                    end
                end else begin
                    state_d = PS_RUN;
                end
            end
            PS_DRAIN: begin
                if (freeze) begin
                    state_d      = PS_MEM_WAIT;
                    wait_cnt_d   = '0;
                    from_drain_d = 1'b1;
                end else if (drain_step) begin
                    if (drain_cnt_q == 3'(PIPE_DRAIN_DEPTH - 1)) begin
                        state_d = PS_HALTED;
                    end
                    drain_cnt_d = drain_cnt_q + 3'd1;
                end
            end
            PS_HALTED: begin
                if (resume_req) begin
                    state_d = PS_RUN;
                end
            end
            PS_FAULT: begin
                state_d = PS_FAULT;
            end
            default: begin
                state_d = PS_RUN;
            end
        endcase
    end

    // State registers with synchronous reset back to RUN.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= PS_RUN;
            wait_cnt_q   <= '0;
            drain_cnt_q  <= '0;
            from_drain_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_cnt_q   <= wait_cnt_d;
            drain_cnt_q  <= drain_cnt_d;
            from_drain_q <= from_drain_d;
        end
    end

    assign halt_ack  = ~rst & (state_q == PS_HALTED);
    assign mem_fault = ~rst & (state_q == PS_FAULT);

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (~rst & ((state_q == PS_RUN) | (state_q == PS_MEM_WAIT)) & ~pc_en),
        .count (stall_cycles)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_redirect_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (pc_sel_redirect),
        .count (redirect_count)
    );

endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Sequencing controller for the five-stage RV32I pipeline. Computes the enable and flush signals for the PC and the four pipeline registers. It resolves three conditions: load-use hazards, EX-stage redirects (taken branch, JAL, JALR) and multi-cycle DMEM accesses. It also provides a debug halt/resume handshake, a DMEM timeout fault and saturating performance counters, and sits beside the combinational `cu` in the core top level.

## Interface
- `TIMEOUT`, 64: maximum consecutive not-ready DMEM cycles before fault; must be ≥2.
- `CNT_WIDTH`, 32: width of performance counters.
- `clk` in 1: core clock.
- `rst` in 1: synchronous, active-high reset.
- `id_rs1`, `id_rs2` in 5: source register addresses of the instruction in ID.
- `id_uses_rs1`, `id_uses_rs2` in 1: the ID instruction actually reads rs1/rs2.
- `ex_rd` in 5: destination register of the instruction in EX.
- `ex_mem_read` in 1: EX instruction is a load (its `D_MEM_read`).
- `ex_redirect` in 1: EX resolved a taken branch, JAL or JALR.
- `mem_req` in 1: MEM instruction accesses DMEM (read or write).
- `dmem_ready` in 1: DMEM completes the access this cycle.
- `halt_req`, `resume_req` in 1: debug halt/resume requests (levels, sampled each cycle).
- `pc_en`, `if_id_en`, `id_ex_en`, `ex_mem_en`, `mem_wb_en` out 1: register load enables.
- `if_id_flush`, `id_ex_flush`, `mem_wb_flush` out 1: load a bubble (all control bits 0) when enabled.
- `pc_sel_redirect` out 1: PC mux selects the EX target.
- `halt_ack` out 1: pipeline drained and halted.
- `mem_fault` out 1: DMEM timeout occurred; sticky.
- `stall_cycles`, `redirect_count` out CNT_WIDTH: performance counters.

## Operation
States are RUN, MEM_WAIT, DRAIN, HALTED and FAULT. Reset enters RUN.

Derived terms:
- `freeze = mem_req & ~dmem_ready`.
- `load_use = ex_mem_read & (ex_rd != 0) & ((id_uses_rs1 & id_rs1 == ex_rd) | (id_uses_rs2 & id_rs2 == ex_rd))`.

Output priority in RUN, MEM_WAIT and DRAIN, highest first:
1. **freeze**: all enables 0 except `mem_wb_en=1` with `mem_wb_flush=1`, so WB sees a bubble and never writes twice. `ex_redirect` is ignored; EX is held, so it re-presents.
2. **ex_redirect**: all enables 1, `pc_sel_redirect=1`, `if_id_flush=1`, `id_ex_flush=1`. This overrides load_use because the ID instruction is squashed.
3. **load_use**: `pc_en=0`, `if_id_en=0`, `id_ex_en=1` with `id_ex_flush=1`. EX, MEM and WB advance.
4. **default**: all enables 1, no flush.

DRAIN additionally forces `if_id_flush=1` whenever `if_id_en=1`. In DRAIN, `pc_en` is 1 only on a redirect, so the resume PC is correct.

HALTED and FAULT: all enables 0, no flush, `pc_sel_redirect=0`.

Transitions:
- **RUN → MEM_WAIT** on freeze.
- **RUN → DRAIN** on `halt_req` when neither freeze nor redirect is active; otherwise the request is retried next cycle.
- **MEM_WAIT**: `wait_cnt` increments each not-ready cycle. On `dmem_ready`, return to the origin state (RUN or DRAIN, recorded in `from_drain`). If `wait_cnt == TIMEOUT-1` and still not ready, go to FAULT.
- **DRAIN**: `drain_cnt` increments on cycles where `id_ex_en` is 1 and both freeze and load_use are 0. At 4 it goes to HALTED. Freeze enters MEM_WAIT with `from_drain=1`; `drain_cnt` is held.
- **HALTED**: `halt_ack=1`. `resume_req` returns to RUN next cycle. `halt_req` is ignored.
- **FAULT**: `mem_fault=1`. Exit only by `rst`.

Counters:
- `stall_cycles` increments on cycles in RUN or MEM_WAIT with `pc_en=0`.
- `redirect_count` increments on cycles where `pc_sel_redirect=1`.
- Both saturate at all-ones.

## Timing
- Enable, flush and `pc_sel_redirect` outputs are combinational (Mealy) from the current state and inputs, with no added latency.
- `halt_ack` and `mem_fault` are decoded from the registered state.
- The state, `wait_cnt`, `drain_cnt`, `from_drain` and the counters update on the `clk` rising edge.
- While `rst=1`: all enables 0, all flushes 0, `pc_sel_redirect=0`, `halt_ack=0`, `mem_fault=0`, counters 0. The state is RUN on the first cycle after `rst` deasserts.
- Reset mid-wait, mid-drain or in FAULT returns to RUN and clears all counters.
- Minimum latencies:
  - `halt_req` to `halt_ack`: 5 cycles (1 to enter DRAIN + 4 drain cycles).
  - Timeout: FAULT is visible TIMEOUT+1 cycles after the first not-ready cycle.

## Structure
- Add to package `rv32i`:
  - `typedef enum logic [2:0] pipe_state_t`.
  - `localparam PIPE_DRAIN_DEPTH = 4`.
- Sub-module `sat_counter` (parameter WIDTH; ports `clk`, `rst`, `inc`, `count`), instantiated twice.

## Test plan
- Load `x5` in EX, ID reads rs2=`x5` -> one cycle with `pc_en=0`, `if_id_en=0`, `id_ex_flush=1`; `stall_cycles`=1. With rd=`x0` -> no stall.
- `ex_redirect=1` with load_use also true -> `pc_sel_redirect=1`, `if_id_flush=id_ex_flush=1`, `pc_en=1`; `redirect_count`=1.
- `mem_req=1`, `dmem_ready` low for 3 cycles -> 3 cycles of full freeze with `mem_wb_flush=1`; back to RUN on the ready cycle; `stall_cycles`=3.
- TIMEOUT=4, `dmem_ready` held low -> `mem_fault=1` from cycle 5; stays set until `rst`, then clears.
- `halt_req` pulse in an idle pipeline -> `halt_ack=1` exactly 5 cycles later, all enables 0; `resume_req` -> RUN and `pc_en=1` the next cycle.
- `halt_req` with a 2-cycle DMEM wait inside DRAIN -> `halt_ack` delayed by 2 cycles, `drain_cnt` preserved; assert `rst` while in DRAIN -> RUN, `halt_ack=0`.
